// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   - opcode encodings for i_op
//   - sequencer state encoding
//   - bit positions inside the 11-bit ALU control word
//   - helpers that build the control word and the DB bus value for an opcode
package alu_seq_pkg;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CTL_W        = 11;
  localparam int CTL_DB_ADD   = 10;
  localparam int CTL_DB_N_ADD = 9;
  localparam int CTL_ADL_ADD  = 8;
  localparam int CTL_0_ADD    = 7;
  localparam int CTL_SB_ADD   = 6;
  localparam int CTL_1_ADDC   = 5;
  localparam int CTL_SUMS     = 4;
  localparam int CTL_ANDS     = 3;
  localparam int CTL_EORS     = 2;
  localparam int CTL_ORS      = 1;
  localparam int CTL_SRS      = 0;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_CMP);
  endfunction

  // Control word for one DRIVE cycle. The A input always comes from SB;
  // LSR and DEC leave every B select off so the ALU sees its precharged 0xFF.
  function automatic logic [CTL_W-1:0] ctl_word(input logic [3:0] op, input logic c);
    logic [CTL_W-1:0] w;
    w = {CTL_W{1'b0}};
    w[CTL_SB_ADD]  = 1'b1;
    w[CTL_ADL_ADD] = 1'b0;
    w[CTL_0_ADD]   = 1'b0;
    case (op)
      OP_ADC: begin w[CTL_DB_ADD]   = 1'b1; w[CTL_SUMS] = 1'b1; w[CTL_1_ADDC] = c;    end
      OP_SBC: begin w[CTL_DB_N_ADD] = 1'b1; w[CTL_SUMS] = 1'b1; w[CTL_1_ADDC] = c;    end
      OP_AND: begin w[CTL_DB_ADD]   = 1'b1; w[CTL_ANDS] = 1'b1;                       end
      OP_ORA: begin w[CTL_DB_ADD]   = 1'b1; w[CTL_ORS]  = 1'b1;                       end
      OP_EOR: begin w[CTL_DB_ADD]   = 1'b1; w[CTL_EORS] = 1'b1;                       end
      OP_LSR: begin w[CTL_SRS]      = 1'b1;                                           end
      OP_INC: begin w[CTL_DB_ADD]   = 1'b1; w[CTL_SUMS] = 1'b1; w[CTL_1_ADDC] = 1'b1; end
      OP_DEC: begin w[CTL_SUMS]     = 1'b1;                                           end
      OP_CMP: begin w[CTL_DB_N_ADD] = 1'b1; w[CTL_SUMS] = 1'b1; w[CTL_1_ADDC] = 1'b1; end
      default: w = {CTL_W{1'b0}};
    endcase
    return w;
  endfunction

  // DB carries the memory operand for two-operand ops; INC adds a zero B.
  function automatic logic [7:0] db_value(input logic [3:0] op, input logic [7:0] m);
    logic [7:0] v;
    case (op)
      OP_ADC, OP_SBC, OP_AND, OP_ORA, OP_EOR, OP_CMP: v = m;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc: ALU-independent reference result and C/V flags.
//   i_op, i_a, i_m, i_c : latched operation and operands
//   o_exp               : 9-bit expected result (bit 8 = carry out for sum ops)
//   o_c                 : expected carry (LSR carry is supplied by the ALU, not here)
//   o_v                 : expected overflow (ADC/SBC only)
module alu_flag_calc (
  input  logic [3:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_m,
  input  logic       i_c,
  output logic [8:0] o_exp,
  output logic       o_c,
  output logic       o_v
);
  import alu_seq_pkg::*;

  logic [7:0] w_b;
  logic       w_cin;
  logic [8:0] w_sum;

  // B operand and carry-in as the ALU would see them for each sum op.
  always_comb begin
    w_b   = 8'h00;
    w_cin = 1'b0;
    case (i_op)
      OP_ADC: begin w_b = i_m;  w_cin = i_c;  end
      OP_SBC: begin w_b = ~i_m; w_cin = i_c;  end
      OP_CMP: begin w_b = ~i_m; w_cin = 1'b1; end
      OP_INC: begin w_b = 8'h00; w_cin = 1'b1; end
      OP_DEC: begin w_b = 8'hFF; w_cin = 1'b0; end
      default: begin w_b = 8'h00; w_cin = 1'b0; end
    endcase
  end

  assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {8'h00, w_cin};

  // Expected result and flags; carry passes through unchanged for non-arithmetic ops.
  always_comb begin
    o_exp = 9'h000;
    o_c   = i_c;
    o_v   = 1'b0;
    case (i_op)
      OP_ADC, OP_SBC: begin
        o_exp = w_sum;
        o_c   = w_sum[8];
        o_v   = (i_a[7] == w_b[7]) && (w_sum[7] != i_a[7]);
      end
      OP_CMP: begin
        o_exp = w_sum;
        o_c   = w_sum[8];
      end
      OP_INC, OP_DEC: o_exp = {1'b0, w_sum[7:0]};
      OP_AND: o_exp = {1'b0, i_a & i_m};
      OP_ORA: o_exp = {1'b0, i_a | i_m};
      OP_EOR: o_exp = {1'b0, i_a ^ i_m};
      OP_LSR: o_exp = {2'b00, i_a[7:1]};
      default: begin
        o_exp = 9'h000;
        o_c   = i_c;
        o_v   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: turns a one-shot request into one cycle of ALU strobes,
// captures the ALU's ADD register and computes flags independently.
//   i_start/i_op/i_a/i_m/i_c : request, sampled only when idle
//   o_db/o_sb/o_alu_ctl      : bus values and strobes, live only in DRIVE
//   i_add/i_acr              : ALU hold register and carry
//   o_busy/o_done            : status; o_done is a one-cycle completion pulse
//   o_result/o_n/o_z/o_c/o_v : captured result and flags, held until next capture
//   o_write/o_error/o_mismatch : completion qualifiers, valid with o_done
module alu_op_sequencer #(
  parameter int CHECK_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_op,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_m,
  input  logic        i_c,
  output logic [7:0]  o_db,
  output logic [7:0]  o_sb,
  output logic [10:0] o_alu_ctl,
  input  logic [7:0]  i_add,
  input  logic        i_acr,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_c,
  output logic        o_v,
  output logic        o_write,
  output logic        o_error,
  output logic        o_mismatch
);
  import alu_seq_pkg::*;

  localparam logic CHECK_ON = (CHECK_EN != 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_legal;

  logic [3:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_m;
  logic        r_c_in;

  logic [7:0]  r_db;
  logic [7:0]  r_sb;
  logic [10:0] r_ctl;

  logic [7:0]  r_result;
  logic        r_n, r_z, r_c, r_v;
  logic        r_busy, r_done, r_write, r_error, r_mismatch;

  logic [8:0]  w_exp;
  logic        w_exp_c;
  logic        w_exp_v;

  assign w_start = (r_state == ST_IDLE) && i_start;
  assign w_legal = op_is_legal(i_op);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: illegal ops skip DRIVE and complete straight away.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_legal) w_state_nxt = ST_DRIVE;
          else         w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op   <= 4'h0;
      r_a    <= 8'h00;
      r_m    <= 8'h00;
      r_c_in <= 1'b0;
    end else if (w_start) begin
      r_op   <= i_op;
      r_a    <= i_a;
      r_m    <= i_m;
      r_c_in <= i_c;
    end
  end

  // Registered decode: strobes and buses are nonzero only during the DRIVE cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctl <= 11'h000;
      r_db  <= 8'h00;
      r_sb  <= 8'h00;
    end else if (w_start && w_legal) begin
      r_ctl <= ctl_word(i_op, i_c);
      r_db  <= db_value(i_op, i_m);
      r_sb  <= i_a;
    end else begin
      r_ctl <= 11'h000;
      r_db  <= 8'h00;
      r_sb  <= 8'h00;
    end
  end

  alu_flag_calc u_flag_calc (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_m   (r_m),
    .i_c   (r_c_in),
    .o_exp (w_exp),
    .o_c   (w_exp_c),
    .o_v   (w_exp_v)
  );

  // Result capture at the edge ending DRIVE; ADD was latched on the DRIVE falling edge.
  // The ALU carry is used only for LSR, where it is the shifted-out bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= 8'h00;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else if (r_state == ST_DRIVE) begin
      r_result <= i_add;
      r_n      <= i_add[7];
      r_z      <= (i_add == 8'h00);
      r_c      <= (r_op == OP_LSR) ? i_acr : w_exp_c;
      r_v      <= w_exp_v;
    end
  end

  // Status and completion qualifiers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_write    <= 1'b0;
      r_error    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_write    <= (r_state == ST_DRIVE) && (r_op != OP_CMP);
      r_error    <= w_start && !w_legal;
      r_mismatch <= CHECK_ON && (r_state == ST_DRIVE) && (i_add != w_exp[7:0]);
    end
  end

  assign o_db       = r_db;
  assign o_sb       = r_sb;
  assign o_alu_ctl  = r_ctl;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_n        = r_n;
  assign o_z        = r_z;
  assign o_c        = r_c;
  assign o_v        = r_v;
  assign o_write    = r_write;
  assign o_error    = r_error;
  assign o_mismatch = r_mismatch;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_c;
  logic [3:0]  i_op;
  logic [7:0]  i_a, i_m;
  logic [7:0]  o_db, o_sb, o_result;
  logic [10:0] o_alu_ctl;
  logic [7:0]  i_add = 8'h00;
  logic        i_acr;
  logic        o_busy, o_done, o_n, o_z, o_c, o_v, o_write, o_error, o_mismatch;

  int n_assert = 0;
  int n_fail   = 0;
  logic bad_alu = 1'b0;

  logic [7:0] prev_res = 8'h00;
  logic       prev_n = 1'b0, prev_z = 1'b0, prev_c = 1'b0, prev_v = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.CHECK_EN(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_m(i_m), .i_c(i_c), .o_db(o_db), .o_sb(o_sb),
    .o_alu_ctl(o_alu_ctl), .i_add(i_add), .i_acr(i_acr), .o_busy(o_busy),
    .o_done(o_done), .o_result(o_result), .o_n(o_n), .o_z(o_z), .o_c(o_c),
    .o_v(o_v), .o_write(o_write), .o_error(o_error), .o_mismatch(o_mismatch)
  );

  // Simple ALU model: input selects from the strobes, ADD latched on the falling edge.
  logic [7:0] alu_a, alu_b;
  logic [8:0] alu_sum;
  always_comb begin
    alu_a   = o_alu_ctl[6] ? o_sb : 8'h00;
    alu_b   = o_alu_ctl[10] ? o_db : (o_alu_ctl[9] ? ~o_db : 8'hFF);
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, o_alu_ctl[5]};
    i_acr   = o_alu_ctl[0] ? alu_a[0] : alu_sum[8];
  end

  always @(negedge clk) begin
    logic [7:0] v;
    if (o_alu_ctl != 11'h000) begin
      if      (o_alu_ctl[4]) v = alu_sum[7:0];
      else if (o_alu_ctl[3]) v = alu_a & alu_b;
      else if (o_alu_ctl[2]) v = alu_a ^ alu_b;
      else if (o_alu_ctl[1]) v = alu_a | alu_b;
      else if (o_alu_ctl[0]) v = {1'b0, alu_a[7:1]};
      else                   v = 8'h00;
      i_add <= v ^ (bad_alu ? 8'h01 : 8'h00);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  // Reference: results and flags from plain integer arithmetic.
  task automatic ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] m,
                        input logic c, output logic [7:0] res, output logic cf,
                        output logic vf, output logic [10:0] ctl, output logic wr,
                        output logic db_used);
    int s, sv;
    res = 8'h00; cf = c; vf = 1'b0; ctl = 11'h000; wr = 1'b1; db_used = 1'b1;
    case (op)
      4'd0: begin
        s = int'(a) + int'(m) + int'(c); sv = sx(a) + sx(m) + int'(c);
        res = s[7:0]; cf = (s > 255); vf = (sv > 127) || (sv < -128);
        ctl = c ? 11'h470 : 11'h450;
      end
      4'd1: begin
        s = int'(a) - int'(m) - (c ? 0 : 1); sv = sx(a) - sx(m) - (c ? 0 : 1);
        res = s[7:0]; cf = (s >= 0); vf = (sv > 127) || (sv < -128);
        ctl = c ? 11'h270 : 11'h250;
      end
      4'd2: begin res = a & m; ctl = 11'h448; end
      4'd3: begin res = a | m; ctl = 11'h442; end
      4'd4: begin res = a ^ m; ctl = 11'h444; end
      4'd5: begin res = a >> 1; cf = a[0]; ctl = 11'h041; db_used = 1'b0; end
      4'd6: begin res = a + 8'd1; ctl = 11'h470; end
      4'd7: begin res = a - 8'd1; ctl = 11'h050; db_used = 1'b0; end
      4'd8: begin
        s = int'(a) - int'(m); res = s[7:0]; cf = (s >= 0);
        ctl = 11'h270; wr = 1'b0;
      end
      default: begin wr = 1'b0; db_used = 1'b0; end
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] m,
                        input logic c, input logic bad);
    logic [7:0]  res, exp_res, exp_db;
    logic        cf, vf, wr, db_used, legal, seen;
    logic [10:0] ctl;
    int          lat;
    ref_op(op, a, m, c, res, cf, vf, ctl, wr, db_used);
    legal   = (op <= 4'd8);
    exp_res = bad ? (res ^ 8'h01) : res;
    exp_db  = (op == 4'd6) ? 8'h00 : m;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    i_start = 1'b1; i_op = op; i_a = a; i_m = m; i_c = c; bad_alu = bad;
    seen = 1'b0; lat = 0;
    for (int cyc = 1; cyc <= 6 && !seen; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (cyc == 1) begin
        chk("drive_ctl", o_alu_ctl, legal ? ctl : 11'h000);
        chk("busy", o_busy, 1);
        if (legal) chk("drive_sb", o_sb, a);
        if (legal && db_used) chk("drive_db", o_db, exp_db);
      end
      if (o_done) begin seen = 1'b1; lat = cyc; end
    end
    chk("latency", lat, legal ? 2 : 1);
    if (seen) begin
      chk("error", o_error, !legal);
      chk("write", o_write, wr);
      chk("mismatch", o_mismatch, legal && bad);
      chk("done_ctl", o_alu_ctl, 0);
      if (legal) begin
        prev_res = exp_res; prev_n = exp_res[7]; prev_z = (exp_res == 8'h00);
        prev_c = cf; prev_v = vf;
      end
      chk("result", o_result, prev_res);
      chk("flag_n", o_n, prev_n);
      chk("flag_z", o_z, prev_z);
      chk("flag_c", o_c, prev_c);
      chk("flag_v", o_v, prev_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {o_db, o_sb, o_alu_ctl, o_busy, o_done, o_result, o_n, o_z, o_c, o_v,
              o_write, o_error, o_mismatch}, 64'h0);
  endtask

  initial begin
    int count;
    logic [7:0]  r_res;
    logic        r_cf, r_vf, r_wr, r_db;
    logic [10:0] r_ctl;
    i_reset = 1'b1; i_start = 1'b0; i_op = 4'h0; i_a = 8'h00; i_m = 8'h00; i_c = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    i_reset = 1'b0;

    run_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0);  // ADC overflow
    run_op(4'd1, 8'h00, 8'h01, 1'b1, 1'b0);  // SBC borrow
    run_op(4'd8, 8'h42, 8'h42, 1'b0, 1'b0);  // CMP equal
    run_op(4'd5, 8'h01, 8'h00, 1'b0, 1'b0);  // LSR to zero, carry from ALU
    run_op(4'd7, 8'h00, 8'h33, 1'b1, 1'b0);  // DEC wrap
    run_op(4'd6, 8'hFF, 8'h00, 1'b0, 1'b0);  // INC wrap
    run_op(4'd0, 8'h12, 8'h34, 1'b1, 1'b1);  // wrong ALU result
    run_op(4'hC, 8'h77, 8'h88, 1'b1, 1'b0);  // illegal opcode

    // start held for six edges: two accepted requests
    @(negedge clk);
    i_start = 1'b1; i_op = 4'd3; i_a = 8'hA5; i_m = 8'h0F; i_c = 1'b1; bad_alu = 1'b0;
    count = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_done) count++;
      if (i == 6) i_start = 1'b0;
    end
    chk("held_start_done_count", count, 2);
    ref_op(4'd3, 8'hA5, 8'h0F, 1'b1, r_res, r_cf, r_vf, r_ctl, r_wr, r_db);
    chk("held_start_result", o_result, r_res);
    prev_res = r_res; prev_n = r_res[7]; prev_z = (r_res == 8'h00); prev_c = r_cf; prev_v = r_vf;

    // reset while driving the ALU
    @(negedge clk);
    i_start = 1'b1; i_op = 4'd0; i_a = 8'hFF; i_m = 8'h01; i_c = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("pre_reset_busy", o_busy, 1);
    i_reset = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_in_drive");
    i_reset = 1'b0;
    prev_res = 8'h00; prev_n = 1'b0; prev_z = 1'b0; prev_c = 1'b0; prev_v = 1'b0;
    run_op(4'd0, 8'hFF, 8'h01, 1'b1, 1'b0);

    // randomized requests, illegal opcodes and faulty ALU results included
    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
